sync_fifo_top: RTL and testbench

//  Synchronous FIFO of wide event rows with a 16-bit serializing read port.

---
 rtl/sync_fifo_top.sv | 150 +++++++++++++++
 tb/tb_sync_fifo_top.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_top.sv
// Row FIFO with a narrow MSB-first serializing read port for SPI readout.
// Define SYNC_FIFO_OVF_FLAG_EN to add the sticky `overflow` output.
module sync_fifo_top #(
  parameter int FIFO_DWIDTH = 136,
  parameter int FIFO_DEPTH  = 16,
  parameter int SPI_DWIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic [FIFO_DWIDTH-1:0]        wdata,
  input  logic                          shift_en,
  output logic [SPI_DWIDTH-1:0]         rdata_spi,
  output logic                          empty,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   numel
`ifdef SYNC_FIFO_OVF_FLAG_EN
  ,
  output logic                          overflow
`endif
);

  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int NW     = AW + 1;
  localparam int NCHUNK = (FIFO_DWIDTH + SPI_DWIDTH - 1) / SPI_DWIDTH;
  localparam int TOTW   = NCHUNK * SPI_DWIDTH;
  localparam int PADW   = TOTW - FIFO_DWIDTH;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  logic [FIFO_DWIDTH-1:0] mem [FIFO_DEPTH];

  logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [NW-1:0] numel_reg, numel_next;
  logic [CW-1:0] chunk_idx_reg, chunk_idx_next;
  logic          empty_reg, empty_next;
  logic          full_reg, full_next;

  logic do_push;
  logic do_shift;
  logic do_pop;

  logic [TOTW-1:0]       head_padded;
  logic [SPI_DWIDTH-1:0] chunk_arr [NCHUNK];
  logic [SPI_DWIDTH-1:0] chunk_sel;

  // Flags are pre-edge values, so a push while full is dropped even if a pop lands.
  assign do_push  = wr_en && !full_reg;
  assign do_shift = shift_en && !empty_reg;
  assign do_pop   = do_shift && (chunk_idx_reg == CW'(NCHUNK - 1));

  // Storage is write-only on the clock; no reset so it maps onto RAM.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= wdata;
    end
  end

  generate
    if (PADW > 0) begin : g_pad
      assign head_padded = {mem[rd_ptr_reg], {PADW{1'b0}}};
    end else begin : g_nopad
      assign head_padded = mem[rd_ptr_reg];
    end
  endgenerate

  genvar gi;
  generate
    for (gi = 0; gi < NCHUNK; gi++) begin : g_chunk
      assign chunk_arr[gi] = head_padded[TOTW-1-gi*SPI_DWIDTH -: SPI_DWIDTH];
    end
  endgenerate

  always_comb begin
    chunk_sel = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      if (chunk_idx_reg == CW'(i)) begin
        chunk_sel = chunk_arr[i];
      end
    end
  end

  assign rdata_spi = empty_reg ? '0 : chunk_sel;

  always_comb begin
    wr_ptr_next    = wr_ptr_reg;
    rd_ptr_next    = rd_ptr_reg;
    numel_next     = numel_reg;
    chunk_idx_next = chunk_idx_reg;

    if (do_push) begin
      wr_ptr_next = wr_ptr_reg + AW'(1);
    end

    if (do_shift) begin
      if (do_pop) begin
        chunk_idx_next = '0;
        rd_ptr_next    = rd_ptr_reg + AW'(1);
      end else begin
        chunk_idx_next = chunk_idx_reg + CW'(1);
      end
    end

    case ({do_push, do_pop})
      2'b10:   numel_next = numel_reg + NW'(1);
      2'b01:   numel_next = numel_reg - NW'(1);
      default: numel_next = numel_reg;
    endcase

    empty_next = (numel_next == NW'(0));
    full_next  = (numel_next == NW'(FIFO_DEPTH));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      numel_reg     <= '0;
      chunk_idx_reg <= '0;
      empty_reg     <= 1'b1;
      full_reg      <= 1'b0;
    end else begin
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      numel_reg     <= numel_next;
      chunk_idx_reg <= chunk_idx_next;
      empty_reg     <= empty_next;
      full_reg      <= full_next;
    end
  end

  assign empty = empty_reg;
  assign full  = full_reg;
  assign numel = numel_reg;

`ifdef SYNC_FIFO_OVF_FLAG_EN
  logic ovf_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_reg <= 1'b0;
    end else if (wr_en && full_reg) begin
      ovf_reg <= 1'b1;
    end
  end

  assign overflow = ovf_reg;
`endif

endmodule

// File: tb/tb_sync_fifo_top.sv
// Scoreboard bench for sync_fifo_top: pushed rows queue their expected chunks,
// each accepted shift pops one chunk and compares it against rdata_spi.
module tb_sync_fifo_top;

  localparam int DW     = 136;
  localparam int DEPTH  = 16;
  localparam int SW     = 16;
  localparam int NCHUNK = 9;

  logic          clk;
  logic          rst;
  logic          wr_en;
  logic [DW-1:0] wdata;
  logic          shift_en;
  logic [SW-1:0] rdata_spi;
  logic          empty;
  logic          full;
  logic [4:0]    numel;
`ifdef SYNC_FIFO_OVF_FLAG_EN
  logic          overflow;
`endif

  sync_fifo_top #(
    .FIFO_DWIDTH(DW),
    .FIFO_DEPTH (DEPTH),
    .SPI_DWIDTH (SW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wdata    (wdata),
    .shift_en (shift_en),
    .rdata_spi(rdata_spi),
    .empty    (empty),
    .full     (full),
    .numel    (numel)
`ifdef SYNC_FIFO_OVF_FLAG_EN
    ,
    .overflow (overflow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [SW-1:0] sb [$];
  int m_numel = 0;
  int m_chunk = 0;

  function automatic logic [SW-1:0] chunk_of(input logic [DW-1:0] row, input int k);
    logic [NCHUNK*SW-1:0] p;
    p = {row, 8'h00};
    return p[NCHUNK*SW-1-k*SW -: SW];
  endfunction

  function automatic logic [DW-1:0] make_row(input int i);
    logic [DW-1:0] r;
    r = {$urandom, $urandom, $urandom, $urandom, 8'(i)};
    return r;
  endfunction

  // Apply inputs for one clock and advance the reference model.
  task automatic step(input logic w, input logic [DW-1:0] d, input logic s);
    logic acc;
    logic pop;
    wr_en    = w;
    wdata    = d;
    shift_en = s;
    acc = w && (m_numel < DEPTH);
    pop = 1'b0;
    if (s && m_numel > 0) begin
      if (m_chunk == NCHUNK - 1) begin
        m_chunk = 0;
        pop = 1'b1;
      end else begin
        m_chunk++;
      end
    end
    if (acc) begin
      for (int k = 0; k < NCHUNK; k++) sb.push_back(chunk_of(d, k));
    end
    m_numel = m_numel + int'(acc) - int'(pop);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; wr_en = 1'b0; wdata = '0; shift_en = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    n_checks++; if (empty !== 1'b1) $display("FAIL reset_empty: got %b expected 1", empty); else n_pass++;
    n_checks++; if (full !== 1'b0) $display("FAIL reset_full: got %b expected 0", full); else n_pass++;
    n_checks++; if (numel !== 5'd0) $display("FAIL reset_numel: got %0d expected 0", numel); else n_pass++;
    n_checks++; if (rdata_spi !== 16'h0) $display("FAIL reset_rdata: got %h expected 0000", rdata_spi); else n_pass++;
`ifdef SYNC_FIFO_OVF_FLAG_EN
    n_checks++; if (overflow !== 1'b0) $display("FAIL reset_overflow: got %b expected 0", overflow); else n_pass++;
`endif
    @(posedge clk); #1;
  endtask

  task automatic test_write_two;
    logic [DW-1:0] r0;
    r0 = make_row(0);
    step(1'b1, r0, 1'b0);
    n_checks++; if (rdata_spi !== r0[135:120]) $display("FAIL first_write_latency: got %h expected %h", rdata_spi, r0[135:120]); else n_pass++;
    step(1'b1, make_row(1), 1'b0);
    step(1'b0, '0, 1'b0);
    n_checks++; if (numel !== 5'd2) $display("FAIL two_rows_numel: got %0d expected 2", numel); else n_pass++;
    n_checks++; if (empty !== 1'b0) $display("FAIL two_rows_empty: got %b expected 0", empty); else n_pass++;
  endtask

  task automatic test_drain_row0;
    logic [SW-1:0] exp;
    for (int k = 0; k < NCHUNK; k++) begin
      repeat (6) step(1'b0, '0, 1'b0);
      exp = sb.pop_front();
      n_checks++; if (rdata_spi !== exp) $display("FAIL row0_chunk%0d: got %h expected %h", k, rdata_spi, exp); else n_pass++;
      if (k == NCHUNK - 1) begin
        n_checks++; if (rdata_spi !== 16'h0000) $display("FAIL row0_last_chunk: got %h expected 0000", rdata_spi); else n_pass++;
      end
      step(1'b0, '0, 1'b1);
    end
    n_checks++; if (numel !== 5'd1) $display("FAIL row0_pop_numel: got %0d expected 1", numel); else n_pass++;
  endtask

  task automatic test_drain_row1;
    logic [SW-1:0] exp;
    for (int k = 0; k < NCHUNK; k++) begin
      exp = sb.pop_front();
      n_checks++; if (rdata_spi !== exp) $display("FAIL row1_chunk%0d: got %h expected %h", k, rdata_spi, exp); else n_pass++;
      if (k == NCHUNK - 1) begin
        n_checks++; if (rdata_spi !== 16'h0100) $display("FAIL row1_last_chunk: got %h expected 0100", rdata_spi); else n_pass++;
      end
      step(1'b0, '0, 1'b1);
    end
    n_checks++; if (empty !== 1'b1) $display("FAIL row1_empty: got %b expected 1", empty); else n_pass++;
    n_checks++; if (numel !== 5'd0) $display("FAIL row1_numel: got %0d expected 0", numel); else n_pass++;
    repeat (3) step(1'b0, '0, 1'b1);
    n_checks++; if (numel !== 5'd0) $display("FAIL shift_empty_numel: got %0d expected 0", numel); else n_pass++;
    n_checks++; if (rdata_spi !== 16'h0) $display("FAIL shift_empty_rdata: got %h expected 0000", rdata_spi); else n_pass++;
  endtask

  task automatic test_fill_overflow;
    logic [SW-1:0] exp;
    for (int i = 0; i < DEPTH; i++) begin
      n_checks++; if (full !== 1'b0) $display("FAIL fill_full_early_%0d: got %b expected 0", i, full); else n_pass++;
      step(1'b1, make_row(16 + i), 1'b0);
    end
    n_checks++; if (full !== 1'b1) $display("FAIL fill_full: got %b expected 1", full); else n_pass++;
    n_checks++; if (numel !== 5'd16) $display("FAIL fill_numel: got %0d expected 16", numel); else n_pass++;
`ifdef SYNC_FIFO_OVF_FLAG_EN
    n_checks++; if (overflow !== 1'b0) $display("FAIL ovf_before_drop: got %b expected 0", overflow); else n_pass++;
`endif
    step(1'b1, make_row(99), 1'b0);
    n_checks++; if (numel !== 5'd16) $display("FAIL drop_numel: got %0d expected 16", numel); else n_pass++;
`ifdef SYNC_FIFO_OVF_FLAG_EN
    n_checks++; if (overflow !== 1'b1) $display("FAIL ovf_after_drop: got %b expected 1", overflow); else n_pass++;
`endif
    // shift_en held high for the whole drain
    for (int n = 0; n < DEPTH * NCHUNK; n++) begin
      exp = sb.pop_front();
      n_checks++; if (rdata_spi !== exp) $display("FAIL drain_chunk%0d: got %h expected %h", n, rdata_spi, exp); else n_pass++;
      step(1'b0, '0, 1'b1);
    end
    step(1'b0, '0, 1'b0);
    n_checks++; if (empty !== 1'b1) $display("FAIL drain_empty: got %b expected 1", empty); else n_pass++;
  endtask

  task automatic test_back_to_back;
    logic [DW-1:0] b;
    logic [SW-1:0] exp;
    step(1'b1, make_row(40), 1'b0);
    for (int k = 0; k < NCHUNK - 1; k++) begin
      exp = sb.pop_front();
      n_checks++; if (rdata_spi !== exp) $display("FAIL b2b_a_chunk%0d: got %h expected %h", k, rdata_spi, exp); else n_pass++;
      step(1'b0, '0, 1'b1);
    end
    b = make_row(41);
    exp = sb.pop_front();
    n_checks++; if (rdata_spi !== exp) $display("FAIL b2b_a_last: got %h expected %h", rdata_spi, exp); else n_pass++;
    step(1'b1, b, 1'b1);
    n_checks++; if (numel !== 5'd1) $display("FAIL b2b_numel: got %0d expected 1", numel); else n_pass++;
    n_checks++; if (rdata_spi !== chunk_of(b, 0)) $display("FAIL b2b_new_head: got %h expected %h", rdata_spi, chunk_of(b, 0)); else n_pass++;
    for (int k = 0; k < NCHUNK; k++) begin
      exp = sb.pop_front();
      n_checks++; if (rdata_spi !== exp) $display("FAIL b2b_b_chunk%0d: got %h expected %h", k, rdata_spi, exp); else n_pass++;
      step(1'b0, '0, 1'b1);
    end
  endtask

  task automatic test_full_push_pop;
    logic [SW-1:0] exp;
    for (int i = 0; i < DEPTH; i++) step(1'b1, make_row(60 + i), 1'b0);
    for (int k = 0; k < NCHUNK - 1; k++) begin
      exp = sb.pop_front();
      n_checks++; if (rdata_spi !== exp) $display("FAIL fpp_chunk%0d: got %h expected %h", k, rdata_spi, exp); else n_pass++;
      step(1'b0, '0, 1'b1);
    end
    exp = sb.pop_front();
    n_checks++; if (rdata_spi !== exp) $display("FAIL fpp_last: got %h expected %h", rdata_spi, exp); else n_pass++;
    step(1'b1, make_row(77), 1'b1);
    n_checks++; if (numel !== 5'd15) $display("FAIL fpp_numel: got %0d expected 15", numel); else n_pass++;
    n_checks++; if (full !== 1'b0) $display("FAIL fpp_full: got %b expected 0", full); else n_pass++;
    for (int n = 0; n < (DEPTH - 1) * NCHUNK; n++) begin
      exp = sb.pop_front();
      n_checks++; if (rdata_spi !== exp) $display("FAIL fpp_drain%0d: got %h expected %h", n, rdata_spi, exp); else n_pass++;
      step(1'b0, '0, 1'b1);
    end
    n_checks++; if (empty !== 1'b1) $display("FAIL fpp_empty: got %b expected 1", empty); else n_pass++;
  endtask

  task automatic test_reset_mid_row;
    logic [DW-1:0] d;
    logic [SW-1:0] exp;
    step(1'b1, make_row(80), 1'b0);
    step(1'b1, make_row(81), 1'b0);
    repeat (3) step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);
    rst = 1'b1;
    #2;
    n_checks++; if (empty !== 1'b1) $display("FAIL midrst_empty: got %b expected 1", empty); else n_pass++;
    n_checks++; if (numel !== 5'd0) $display("FAIL midrst_numel: got %0d expected 0", numel); else n_pass++;
    n_checks++; if (rdata_spi !== 16'h0) $display("FAIL midrst_rdata: got %h expected 0000", rdata_spi); else n_pass++;
`ifdef SYNC_FIFO_OVF_FLAG_EN
    n_checks++; if (overflow !== 1'b0) $display("FAIL midrst_overflow: got %b expected 0", overflow); else n_pass++;
`endif
    @(posedge clk);
    #1 rst = 1'b0;
    sb.delete();
    m_numel = 0;
    m_chunk = 0;
    d = make_row(90);
    step(1'b1, d, 1'b0);
    n_checks++; if (rdata_spi !== chunk_of(d, 0)) $display("FAIL midrst_chunk0: got %h expected %h", rdata_spi, chunk_of(d, 0)); else n_pass++;
    n_checks++; if (numel !== 5'd1) $display("FAIL midrst_refill_numel: got %0d expected 1", numel); else n_pass++;
    for (int k = 0; k < NCHUNK; k++) begin
      exp = sb.pop_front();
      n_checks++; if (rdata_spi !== exp) $display("FAIL midrst_chunk%0d: got %h expected %h", k, rdata_spi, exp); else n_pass++;
      step(1'b0, '0, 1'b1);
    end
    n_checks++; if (empty !== 1'b1) $display("FAIL midrst_final_empty: got %b expected 1", empty); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_write_two();
    test_drain_row0();
    test_drain_row1();
    test_fill_overflow();
    test_back_to_back();
    test_full_push_pop();
    test_reset_mid_row();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
